// File: rtl/stage3_ex_pkg.sv
// Shared constants for the execute stage: bus widths, ID->EX field offsets, op encodings.
package stage3_ex_pkg;

  localparam int unsigned DsToEsW = 153;
  localparam int unsigned EsToMsW = 71;
  localparam int unsigned EsToDsW = 39;

  // ID->EX bus field offsets
  localparam int unsigned DsPcLsb       = 0;
  localparam int unsigned DsRjLsb       = 32;
  localparam int unsigned DsRkdLsb      = 64;
  localparam int unsigned DsImmLsb      = 96;
  localparam int unsigned DsDestLsb     = 128;
  localparam int unsigned DsGrWe        = 133;
  localparam int unsigned DsMemWe       = 134;
  localparam int unsigned DsAluOpLsb    = 135;
  localparam int unsigned DsSrc1IsPc    = 147;
  localparam int unsigned DsSrc2IsImm   = 148;
  localparam int unsigned DsResFromMem  = 149;
  localparam int unsigned DsMdOpLsb     = 150;

  // One-hot ALU op bit indices
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef enum logic [2:0] {
    MdNone   = 3'd0,
    MdMulW   = 3'd1,
    MdMulhW  = 3'd2,
    MdMulhWu = 3'd3,
    MdDivW   = 3'd4,
    MdModW   = 3'd5,
    MdDivWu  = 3'd6,
    MdModWu  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  // Every divide/modulo encoding has bit 2 set.
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Restoring radix-2 divider: 32 iteration cycles after a start pulse, q/r held until next start.
module ex_divider
  import stage3_ex_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        b_zero_q, b_zero_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // Iteration datapath: shift next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
  end

  // Next-state: load magnitudes on start, otherwise step while busy.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    b_zero_d = b_zero_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = (is_signed && a[31]) ? (~a + 32'd1) : a;
      dvs_d    = (is_signed && b[31]) ? (~b + 32'd1) : b;
      q_neg_d  = is_signed & (a[31] ^ b[31]);
      r_neg_d  = is_signed & a[31];
      b_zero_d = (b == 32'd0);
    end else if (busy_q) begin
      rem_d = ge ? diff[31:0] : shifted[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      b_zero_q <= b_zero_d;
    end
  end

  // done marks the final iteration cycle; q/r are valid from the following cycle.
  // With b=0 the remainder path shifts the whole dividend through, giving r=a naturally.
  always_comb begin
    busy = busy_q;
    done = busy_q & (cnt_q == 5'd31);
    q    = b_zero_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
    r    = r_neg_q ? (~rem_q + 32'd1) : rem_q;
  end

endmodule

// File: rtl/stage3_ex.sv
// Execute stage: ID->EX latch, ALU, single-cycle multiplier, iterative divider, data-SRAM request.
module stage3_ex
  import stage3_ex_pkg::*;
#(
  parameter int unsigned DS_TO_ES_W = DsToEsW,
  parameter int unsigned ES_TO_MS_W = EsToMsW,
  parameter int unsigned ES_TO_DS_W = EsToDsW
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ds_to_es_valid,
  output logic                  es_allow_in,
  input  logic [DS_TO_ES_W-1:0] ds_to_es_bus,
  input  logic                  ms_allow_in,
  output logic                  es_to_ms_valid,
  output logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_W-1:0] es_to_ds_bus,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata
);

  logic                  es_valid_q;
  logic [DS_TO_ES_W-1:0] bus_q;
  div_state_e            state_q, state_d;
  logic                  es_ready_go;
  logic                  div_start, div_busy, div_done;
  logic [31:0]           div_q, div_r;

  // Field decode of the latched bus
  logic [31:0] pc, rj, rkd, imm, src1, src2;
  logic [4:0]  dest;
  logic [11:0] alu_op;
  logic        gr_we, mem_we, src1_is_pc, src2_is_imm, res_from_mem, is_div, div_signed;
  md_op_e      md_op;

  assign pc           = bus_q[DsPcLsb +: 32];
  assign rj           = bus_q[DsRjLsb +: 32];
  assign rkd          = bus_q[DsRkdLsb +: 32];
  assign imm          = bus_q[DsImmLsb +: 32];
  assign dest         = bus_q[DsDestLsb +: 5];
  assign gr_we        = bus_q[DsGrWe];
  assign mem_we       = bus_q[DsMemWe];
  assign alu_op       = bus_q[DsAluOpLsb +: 12];
  assign src1_is_pc   = bus_q[DsSrc1IsPc];
  assign src2_is_imm  = bus_q[DsSrc2IsImm];
  assign res_from_mem = bus_q[DsResFromMem];
  assign md_op        = md_op_e'(bus_q[DsMdOpLsb +: 3]);
  assign src1         = src1_is_pc ? pc : rj;
  assign src2         = src2_is_imm ? imm : rkd;
  assign is_div       = md_is_div(md_op);
  assign div_signed   = (md_op == MdDivW) || (md_op == MdModW);

  // Pipeline handshake
  assign es_ready_go    = !is_div || (state_q == DivDone);
  assign es_allow_in    = !es_valid_q || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  // Stage valid and bus latch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      if (es_allow_in) begin
        es_valid_q <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allow_in) begin
        bus_q <= ds_to_es_bus;
      end
    end
  end

  // ALU: shared adder for add/sub/compare, AND-OR merge of the one-hot op results.
  logic        sub_like;
  logic [32:0] add_res;
  logic        slt_res, sltu_res;
  logic [31:0] alu_result;

  always_comb begin
    sub_like   = alu_op[AluSub] | alu_op[AluSlt] | alu_op[AluSltu];
    add_res    = {1'b0, src1} + {1'b0, (sub_like ? ~src2 : src2)} + {32'd0, sub_like};
    slt_res    = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & add_res[31]);
    sltu_res   = ~add_res[32];
    alu_result = '0;
    if (alu_op[AluAdd] || alu_op[AluSub]) alu_result |= add_res[31:0];
    if (alu_op[AluSlt])  alu_result |= {31'd0, slt_res};
    if (alu_op[AluSltu]) alu_result |= {31'd0, sltu_res};
    if (alu_op[AluAnd])  alu_result |= src1 & src2;
    if (alu_op[AluNor])  alu_result |= ~(src1 | src2);
    if (alu_op[AluOr])   alu_result |= src1 | src2;
    if (alu_op[AluXor])  alu_result |= src1 ^ src2;
    if (alu_op[AluSll])  alu_result |= src1 << src2[4:0];
    if (alu_op[AluSrl])  alu_result |= src1 >> src2[4:0];
    if (alu_op[AluSra])  alu_result |= $unsigned($signed(src1) >>> src2[4:0]);
    if (alu_op[AluLui])  alu_result |= src2;
  end

  // Multiplier: 66-bit operands so signed and unsigned share one product.
  logic        mul_signed;
  logic [65:0] mul_a, mul_b, mul_prod;

  always_comb begin
    mul_signed = (md_op == MdMulW) || (md_op == MdMulhW);
    mul_a      = {{34{mul_signed & rj[31]}}, rj};
    mul_b      = {{34{mul_signed & rkd[31]}}, rkd};
    mul_prod   = mul_a * mul_b;
  end

  // Result select: any md_op overrides the ALU.
  logic [31:0] result;

  always_comb begin
    case (md_op)
      MdNone:            result = alu_result;
      MdMulW:            result = mul_prod[31:0];
      MdMulhW, MdMulhWu: result = mul_prod[63:32];
      MdDivW, MdDivWu:   result = div_q;
      default:           result = div_r;
    endcase
  end

  // Divide FSM next-state; start pulses once from IDLE for a valid divide.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      DivIdle: begin
        if (es_valid_q && is_div) begin
          div_start = 1'b1;
          state_d   = DivBusy;
        end
      end
      DivBusy: begin
        if (div_busy && div_done) state_d = DivDone;
      end
      DivDone: begin
        if (es_to_ms_valid && ms_allow_in) state_d = DivIdle;
      end
      default: state_d = DivIdle;
    endcase
  end

  // Divide FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  ex_divider u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .is_signed (div_signed),
    .a         (rj),
    .b         (rkd),
    .busy      (div_busy),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  // Memory request only on the handoff cycle so a stalled access is issued exactly once.
  logic es_we, es_block;

  always_comb begin
    data_sram_en    = es_valid_q & (mem_we | res_from_mem) & es_ready_go & ms_allow_in;
    data_sram_we    = {4{data_sram_en & mem_we}};
    data_sram_addr  = rj + imm;
    data_sram_wdata = rkd;
    es_we           = es_valid_q & gr_we;
    es_block        = res_from_mem | (is_div & (state_q != DivDone));
    es_to_ms_bus    = {res_from_mem, gr_we, dest, result, pc};
    es_to_ds_bus    = {es_we, dest, es_block, result};
  end

endmodule

// File: tb/tb_stage3_ex.sv
// Directed self-checking bench for the execute stage.
module tb_stage3_ex;

  logic         clk;
  logic         resetn;
  logic         ds_to_es_valid;
  logic         es_allow_in;
  logic [152:0] ds_to_es_bus;
  logic         ms_allow_in;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;

  stage3_ex dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allow_in     (es_allow_in),
    .ds_to_es_bus    (ds_to_es_bus),
    .ms_allow_in     (ms_allow_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_bus    (es_to_ds_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [152:0] mk_bus(input logic [31:0] pc, input logic [31:0] rj,
                                          input logic [31:0] rkd, input logic [31:0] imm,
                                          input logic [4:0] dest, input logic gr_we,
                                          input logic mem_we, input logic [11:0] alu_op,
                                          input logic s1pc, input logic s2imm,
                                          input logic rfm, input logic [2:0] md);
    logic [152:0] b;
    b = '0;
    b[31:0]    = pc;
    b[63:32]   = rj;
    b[95:64]   = rkd;
    b[127:96]  = imm;
    b[132:128] = dest;
    b[133]     = gr_we;
    b[134]     = mem_we;
    b[146:135] = alu_op;
    b[147]     = s1pc;
    b[148]     = s2imm;
    b[149]     = rfm;
    b[152:150] = md;
    return b;
  endfunction

  // Present one instruction for one edge; returns #1 after the edge it was latched on.
  task automatic issue(input logic [152:0] b);
    ds_to_es_bus   = b;
    ds_to_es_valid = 1'b1;
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    ms_allow_in    = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk_bus(32'h1C00_0000, 32'd1, 32'd2, 32'd0, 5'd1, 1'b1, 1'b0, 12'h001,
                            1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (es_to_ms_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%b want=0", es_to_ms_valid); end
    total++; if (data_sram_en !== 1'b0) begin bad++;
      $display("FAIL reset_en got=%b want=0", data_sram_en); end
    total++; if (es_allow_in !== 1'b1) begin bad++;
      $display("FAIL reset_allow_in got=%b want=1", es_allow_in); end
    total++; if (es_to_ds_bus[38] !== 1'b0 || data_sram_we !== 4'h0) begin bad++;
      $display("FAIL reset_we got=%b/%h want=0/0", es_to_ds_bus[38], data_sram_we); end
    ds_to_es_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_add();
    issue(mk_bus(32'h1C00_0010, 32'd7, 32'd5, 32'd0, 5'd3, 1'b1, 1'b0, 12'h001,
                 1'b0, 1'b0, 1'b0, 3'd0));
    total++; if (es_to_ms_valid !== 1'b1) begin bad++;
      $display("FAIL add_valid got=%b want=1", es_to_ms_valid); end
    total++; if (es_to_ms_bus[63:32] !== 32'd12) begin bad++;
      $display("FAIL add_result got=%h want=0000000c", es_to_ms_bus[63:32]); end
    total++; if (es_to_ms_bus[31:0] !== 32'h1C00_0010 || es_to_ms_bus[70:64] !== 7'b0100011)
      begin bad++;
      $display("FAIL add_fields got=%h/%b want=1c000010/0100011", es_to_ms_bus[31:0],
               es_to_ms_bus[70:64]); end
    total++; if (es_to_ds_bus !== {1'b1, 5'd3, 1'b0, 32'd12}) begin bad++;
      $display("FAIL add_fwd got=%h want=%h", es_to_ds_bus, {1'b1, 5'd3, 1'b0, 32'd12}); end
    total++; if (data_sram_en !== 1'b0) begin bad++;
      $display("FAIL add_no_mem got=%b want=0", data_sram_en); end
  endtask

  task automatic test_alu();
    logic [11:0] ops [12];
    logic [31:0] a [12];
    logic [31:0] b [12];
    logic [31:0] e [12];
    ops = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
            12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h001};
    a   = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h00FF_0000,
            32'hFFFF_0000, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0};
    b   = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h00F0_000F, 32'h0000_00FF,
            32'h0F0F_0F0F, 32'h0000_0023, 32'd4, 32'd4, 32'h1234_5000, 32'd4};
    e   = '{32'hFFFF_FFFE, 32'd1, 32'd1, 32'hF000_F000, 32'hF000_FFF0, 32'h00FF_00FF,
            32'hF0F0_0F0F, 32'd8, 32'h0800_0000, 32'hF800_0000, 32'h1234_5000, 32'h1C00_0004};
    // lui and the pc-relative add take src2 from imm; the last entry also takes src1 from pc.
    for (int i = 0; i < 12; i++) begin
      issue(mk_bus(32'h1C00_0000, a[i], (i >= 10) ? 32'hAAAA_AAAA : b[i],
                   (i >= 10) ? b[i] : 32'h5555_5555, 5'd4, 1'b1, 1'b0, ops[i],
                   (i == 11), (i >= 10), 1'b0, 3'd0));
      total++; if (es_to_ms_bus[63:32] !== e[i] || es_to_ms_valid !== 1'b1) begin bad++;
        $display("FAIL alu_%0d got=%h/%b want=%h/1", i, es_to_ms_bus[63:32], es_to_ms_valid,
                 e[i]); end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  md [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] e [4];
    md = '{3'd3, 3'd1, 3'd2, 3'd1};
    a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1234_5678};
    b  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h10};
    e  = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h2345_6780};
    for (int i = 0; i < 4; i++) begin
      issue(mk_bus(32'd0, a[i], b[i], 32'd0, 5'd6, 1'b1, 1'b0, 12'h001,
                   1'b0, 1'b0, 1'b0, md[i]));
      total++; if (es_to_ms_bus[63:32] !== e[i] || es_to_ms_valid !== 1'b1) begin bad++;
        $display("FAIL mul_%0d got=%h/%b want=%h/1", i, es_to_ms_bus[63:32], es_to_ms_valid,
                 e[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mem();
    ms_allow_in = 1'b0;
    issue(mk_bus(32'd0, 32'h100, 32'hDEAD_BEEF, 32'd8, 5'd0, 1'b0, 1'b1, 12'h001,
                 1'b0, 1'b1, 1'b0, 3'd0));
    for (int i = 0; i < 3; i++) begin
      total++; if (data_sram_en !== 1'b0 || es_allow_in !== 1'b0) begin bad++;
        $display("FAIL st_stall_%0d got=en%b/allow%b want=0/0", i, data_sram_en,
                 es_allow_in); end
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    ms_allow_in = 1'b1;
    #1;
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'hF) begin bad++;
      $display("FAIL st_req got=en%b/we%h want=1/f", data_sram_en, data_sram_we); end
    total++; if (data_sram_addr !== 32'h108 || data_sram_wdata !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL st_addr got=%h/%h want=00000108/deadbeef", data_sram_addr,
               data_sram_wdata); end
    @(posedge clk);
    #1;
    total++; if (data_sram_en !== 1'b0 || es_to_ms_valid !== 1'b0) begin bad++;
      $display("FAIL st_once got=en%b/v%b want=0/0", data_sram_en, es_to_ms_valid); end
    issue(mk_bus(32'd0, 32'h200, 32'd0, 32'd4, 5'd9, 1'b1, 1'b0, 12'h001,
                 1'b0, 1'b1, 1'b1, 3'd0));
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0 || data_sram_addr !== 32'h204)
      begin bad++;
      $display("FAIL ld_req got=en%b/we%h/%h want=1/0/00000204", data_sram_en, data_sram_we,
               data_sram_addr); end
    total++; if (es_to_ds_bus[32] !== 1'b1 || es_to_ms_bus[70] !== 1'b1) begin bad++;
      $display("FAIL ld_block got=%b/%b want=1/1", es_to_ds_bus[32], es_to_ms_bus[70]); end
    @(posedge clk);
    #1;
  endtask

  // One divide from entry to handoff; optionally hold MEM off for `stall` cycles in DONE.
  task automatic test_div(input string nm, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall);
    int cnt;
    int viol;
    cnt  = 0;
    viol = 0;
    if (stall > 0) ms_allow_in = 1'b0;
    issue(mk_bus(32'd0, a, b, 32'd0, 5'd7, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, md));
    for (int i = 0; i < 40; i++) begin
      if (es_to_ms_valid === 1'b1) break;
      if (es_allow_in !== 1'b0 || es_to_ds_bus[32] !== 1'b1) viol++;
      cnt++;
      @(posedge clk);
      #1;
    end
    total++; if (cnt != 33) begin bad++;
      $display("FAIL %s_cycles got=%0d want=33", nm, cnt); end
    total++; if (viol != 0) begin bad++;
      $display("FAIL %s_busy_flags got=%0d bad cycles want=0", nm, viol); end
    for (int i = 0; i < stall; i++) begin
      total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== exp) begin bad++;
        $display("FAIL %s_hold_%0d got=%b/%h want=1/%h", nm, i, es_to_ms_valid,
                 es_to_ms_bus[63:32], exp); end
      @(posedge clk);
      #1;
    end
    ms_allow_in = 1'b1;
    #1;
    total++; if (es_to_ms_bus[63:32] !== exp || es_to_ds_bus[32] !== 1'b0 ||
                 es_allow_in !== 1'b1) begin bad++;
      $display("FAIL %s_result got=%h/blk%b/allow%b want=%h/0/1", nm, es_to_ms_bus[63:32],
               es_to_ds_bus[32], es_allow_in, exp); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    issue(mk_bus(32'd0, 32'd100, 32'd7, 32'd0, 5'd8, 1'b1, 1'b0, 12'h000,
                 1'b0, 1'b0, 1'b0, 3'd6));
    ds_to_es_bus   = mk_bus(32'd0, 32'd100, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0, 12'h000,
                            1'b0, 1'b0, 1'b0, 3'd7);
    ds_to_es_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (es_to_ms_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd14 ||
                 es_allow_in !== 1'b1) begin bad++;
      $display("FAIL b2b_first got=%b/%h/%b want=1/0000000e/1", es_to_ms_valid,
               es_to_ms_bus[63:32], es_allow_in); end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (es_to_ms_valid === 1'b1) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    total++; if (cnt != 33 || es_to_ms_bus[63:32] !== 32'd2 || es_to_ms_bus[68:64] !== 5'd9)
      begin bad++;
      $display("FAIL b2b_second got=%0d/%h/%0d want=33/00000002/9", cnt, es_to_ms_bus[63:32],
               es_to_ms_bus[68:64]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_div();
    issue(mk_bus(32'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd7, 1'b1, 1'b0, 12'h000,
                 1'b0, 1'b0, 1'b0, 3'd4));
    repeat (11) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    total++; if (es_to_ms_valid !== 1'b0 || es_allow_in !== 1'b1 || es_to_ds_bus[38] !== 1'b0
                 || es_to_ds_bus[32] !== 1'b0) begin bad++;
      $display("FAIL mid_div_reset got=v%b/a%b/we%b/blk%b want=0/1/0/0", es_to_ms_valid,
               es_allow_in, es_to_ds_bus[38], es_to_ds_bus[32]); end
    resetn = 1'b1;
    issue(mk_bus(32'd0, 32'd1, 32'd2, 32'd0, 5'd1, 1'b1, 1'b0, 12'h001,
                 1'b0, 1'b0, 1'b0, 3'd0));
    total++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd3) begin bad++;
      $display("FAIL post_reset_add got=%b/%h want=1/00000003", es_to_ms_valid,
               es_to_ms_bus[63:32]); end
    @(posedge clk);
    #1;
    // A fresh divide must take the full latency again, proving the FSM restarted from IDLE.
    test_div("post_reset_div", 3'd6, 32'd50, 32'd5, 32'd10, 0);
  endtask

  initial begin
    resetn         = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ms_allow_in    = 1'b1;
    test_reset();
    test_add();
    test_alu();
    test_mul();
    test_mem();
    test_div("div_w", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    test_div("mod_w", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 2);
    test_div("div_wu_zero", 3'd6, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    test_div("mod_wu_zero", 3'd7, 32'd9, 32'd0, 32'd9, 0);
    test_div("div_w_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    test_div("mod_w_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
